spike_array_driver: RTL and testbench
=====================================

// Module: spike_array_driver
// PURPOSE
// Initiator/feeder for the spike MAC array. Accepts a batch command, streams N-lane weight/activation
// vectors into the array (one start pulse per vector) and collects the array's done/result returns.
// Results are buffered in a credit-protected FIFO with an output handshake, and summed per batch.
// Sits between the operand source (DMA/testbench) and the array; the array itself has no backpressure.
// PARAMETERS
// N          128  lanes per vector (weights 4 b/lane, activations BITWIDTH b/lane)
// BITWIDTH   4    activation width per lane, two's complement
// FIFO_DEPTH 16   result FIFO entries (power of 2); also the in-flight credit limit
// LEN_W      10   batch-length width; max batch = 2^LEN_W-1 vectors
// PORTS
// clk             in   1            clock, all logic on posedge
// rst             in   1            asynchronous, active-high reset
// cmd_valid       in   1            batch command valid
// cmd_ready       out  1            high only in IDLE
// cmd_len         in   LEN_W        vectors in batch (0 allowed)
// s_valid         in   1            operand vector valid
// s_ready         out  1            operand vector accepted when s_valid&s_ready
// s_weights       in   N*4          weight lanes, lane t at [t*4+:4]
// s_acts          in   N*BITWIDTH   activation lanes, lane t at [t*BITWIDTH+:BITWIDTH]
// o_weights_flat  out  N*4          registered to array
// o_acts_flat     out  N*BITWIDTH   registered to array
// o_start         out  1            registered 1-cycle start pulse to array
// i_done          in   1            array result strobe (one per start)
// i_result        in   16           array result, signed
// m_valid/m_ready out/in 1          result stream handshake
// m_data          out  16           FIFO head result
// m_last          out  1            head is last result of its batch
// batch_done      out  1            1-cycle pulse: all results of batch received
// batch_sum       out  32           signed sum of batch results, valid while batch_done high
// err_unexp       out  1            sticky: i_done seen with zero in flight
// BEHAVIOUR
// - Reset (async): FSM=IDLE, all counters/FIFO cleared, o_start=0, o_*_flat=0, m_valid=0, batch_done=0,
//   batch_sum=0, err_unexp=0. Reset mid-batch discards in-flight work; late i_done after reset sets err_unexp.
// - FSM: IDLE -cmd_valid&cmd_ready-> ISSUE (len>0) or FINISH (len=0); ISSUE -issued==len-> DRAIN;
//   DRAIN -received==len-> FINISH; FINISH -> IDLE (one cycle, batch_done=1).
// - s_ready = (state==ISSUE) & (issued<len) & (inflight+fifo_count < FIFO_DEPTH). No combinational
//   s_valid->s_ready path.
// - On accept edge: o_*_flat <= s_*, o_start <= 1 next cycle only; issued++, inflight++. Back-to-back
//   accepts allowed (one start per cycle).
// - i_done: push i_result into FIFO with last flag (received==len-1), inflight--, received++,
//   acc += sign-extended i_result (32 b, wraps, no saturation). Same-cycle accept and i_done: inflight unchanged.
// - Credit rule guarantees FIFO never overflows; i_done with inflight==0 dropped, err_unexp<=1.
// - FIFO: first-word-fall-through; m_valid=~empty; pop on m_valid&m_ready; simultaneous push/pop
//   at full or empty is legal; count unchanged.
// - FINISH: batch_sum <= acc, batch_done=1 for one cycle, acc cleared; FIFO contents of the finished batch
//   remain and drain independently; next command accepted from IDLE even if FIFO non-empty.
// - Latency with array attached: o_start 1 cycle after accept; m_valid 10 edges after accept edge if FIFO empty.
// TESTING
// - cmd_len=1, one vector of all weights 1, acts 1 -> o_start 1 pulse; m_data=128, m_last=1; batch_sum=128.
// - cmd_len=4, s_valid held high, m_ready=1 -> 4 consecutive start pulses, 4 results in order, batch_done once.
// - cmd_len=40, m_ready=0 -> s_ready drops after 16 accepts; no FIFO overflow; release m_ready -> 40 results.
// - cmd_len=0 -> no o_start, batch_done 1 cycle after accept, batch_sum=0, cmd_ready back next cycle.
// - Assert rst during DRAIN with 3 in flight -> outputs at reset values same cycle; 3 late i_done -> err_unexp=1.
// - Results +32767 and -32768 alternating (via stub array), len=6 -> batch_sum=-3, m_data sign intact.

Source files
------------

// File: rtl/spike_array_driver.sv
// Feeds operand vectors to the spike MAC array one start pulse at a time, collects the returned
// results into a credit-protected FWFT FIFO and reports a per-batch signed sum.
module spike_array_driver #(
    parameter int N          = 128,
    parameter int BITWIDTH   = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [N*4-1:0]        s_weights,
    input  logic [N*BITWIDTH-1:0] s_acts,
    output logic [N*4-1:0]        o_weights_flat,
    output logic [N*BITWIDTH-1:0] o_acts_flat,
    output logic                  o_start,
    input  logic                  i_done,
    input  logic [15:0]           i_result,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [15:0]           m_data,
    output logic                  m_last,
    output logic                  batch_done,
    output logic [31:0]           batch_sum,
    output logic                  err_unexp,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends
    // combinationally on the matching valid, and the array side (o_start / i_done) has no backpressure.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t             state, next_state;
    logic [LEN_W-1:0]   len_q, issued, received;
    logic [CNT_W-1:0]   inflight, fifo_count;
    logic [CNT_W:0]     credit_used;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [16:0]        fifo_mem [FIFO_DEPTH];
    logic [16:0]        head;
    logic [31:0]        acc;
    logic               cmd_fire, s_fire, done_ok, pop, last_flag;

    // Results already queued plus results still inside the array may never exceed the FIFO size.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign s_ready     = (state == S_ISSUE) && (issued != len_q) &&
                         (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign s_fire      = s_valid && s_ready;
    assign done_ok     = i_done && (inflight != '0);
    assign pop         = m_valid && m_ready;
    assign last_flag   = (received == len_q - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (cmd_fire) next_state = (cmd_len == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE:  if (issued == len_q) next_state = S_DRAIN;
            S_DRAIN:  if (received == len_q) next_state = S_FINISH;
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == S_IDLE);
        batch_done = (state == S_FINISH);
        dbg_state  = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            issued   <= '0;
            received <= '0;
            inflight <= '0;
        end else begin
            if (cmd_fire) begin
                len_q    <= cmd_len;
                issued   <= '0;
                received <= '0;
            end else begin
                if (s_fire)  issued   <= issued + LEN_W'(1);
                if (done_ok) received <= received + LEN_W'(1);
            end
            case ({s_fire, done_ok})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_start        <= 1'b0;
            o_weights_flat <= '0;
            o_acts_flat    <= '0;
            err_unexp      <= 1'b0;
        end else begin
            o_start <= s_fire;
            if (s_fire) begin
                o_weights_flat <= s_weights;
                o_acts_flat    <= s_acts;
            end
            if (i_done && (inflight == '0)) err_unexp <= 1'b1;
        end
    end

    // The sum is latched on entry to FINISH so it is already valid while batch_done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            batch_sum <= '0;
        end else if (next_state == S_FINISH) begin
            batch_sum <= acc;
            acc       <= '0;
        end else if (done_ok) begin
            acc <= acc + {{16{i_result[15]}}, i_result};
        end
    end

    always_ff @(posedge clk) begin
        if (done_ok) fifo_mem[wr_ptr] <= {last_flag, i_result};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (done_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (done_ok && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !done_ok) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    assign m_valid = (fifo_count != '0);
    assign head    = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_data  = head[15:0];
    assign m_last  = head[16];

endmodule

// File: tb/tb_spike_array_driver.sv
// Bench for spike_array_driver: a delayed-result array stub, a result scoreboard, a table of uniform
// batches and hand-written sequences for backpressure, zero-length, sign extremes and mid-batch reset.
module tb_spike_array_driver;

    localparam int N = 128;
    localparam int BW = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int LEN_W = 10;
    localparam int NW = N * 4;
    localparam int NA = N * BW;
    localparam int STUB_DELAY = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              s_valid, s_ready;
    logic [NW-1:0]     s_weights, o_weights_flat;
    logic [NA-1:0]     s_acts, o_acts_flat;
    logic              o_start, i_done;
    logic [15:0]       i_result, m_data;
    logic              m_valid, m_ready, m_last, batch_done, err_unexp;
    logic [31:0]       batch_sum;
    logic [1:0]        dbg_state;

    spike_array_driver #(.N(N), .BITWIDTH(BW), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_weights(s_weights), .s_acts(s_acts),
        .o_weights_flat(o_weights_flat), .o_acts_flat(o_acts_flat), .o_start(o_start),
        .i_done(i_done), .i_result(i_result), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .batch_done(batch_done), .batch_sum(batch_sum),
        .err_unexp(err_unexp), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    logic [15:0] force_q[$];
    int start_cnt = 0, run_len = 0, max_run = 0, done_cnt = 0, pop_cnt = 0;
    logic [31:0] sum_at_done = '0;
    logic        stub_v [STUB_DELAY];
    logic [15:0] stub_d [STUB_DELAY];

    typedef struct {
        int         len;
        logic [3:0] w;
        logic [3:0] a;
        int         exp_sum;
    } batch_rec_t;
    batch_rec_t tbl[4];

    function automatic logic [15:0] dot16(input logic [NW-1:0] w, input logic [NA-1:0] a);
        int s = 0;
        logic [3:0] wv;
        logic signed [BW-1:0] av;
        for (int t = 0; t < N; t++) begin
            wv = w[t*4 +: 4];
            av = a[t*BW +: BW];
            s += int'(wv) * int'(av);
        end
        return s[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no event, expected one", name);
    endtask

    task automatic send_cmd(input int len);
        int waited = 0;
        while (!cmd_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 500) begin timeout_fail("cmd_ready_wait"); return; end
        end
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [NW-1:0] w, input logic [NA-1:0] a, input logic [16:0] exp);
        int waited = 0;
        s_weights = w;
        s_acts    = a;
        s_valid   = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 500) begin
                timeout_fail("s_ready_wait");
                s_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int waited = 0;
        while (done_cnt == prev) begin
            @(negedge clk);
            waited++;
            if (waited > 1000) begin timeout_fail("batch_done_wait"); return; end
        end
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            waited++;
            if (waited > 1000) begin timeout_fail("drain_wait"); return; end
        end
    endtask

    initial begin
        logic [NW-1:0] w;
        logic [NA-1:0] a;
        logic [15:0]   r;
        int            model_sum, d0, s0, p0, bad;

        rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; s_valid = 1'b0;
        s_weights = '0; s_acts = '0; i_done = 1'b0; i_result = '0; m_ready = 1'b1;
        for (int i = 0; i < STUB_DELAY; i++) begin stub_v[i] = 1'b0; stub_d[i] = '0; end

        tbl[0] = '{len: 1, w: 4'd1,  a: 4'd1, exp_sum: 128};
        tbl[1] = '{len: 4, w: 4'd2,  a: 4'd3, exp_sum: 3072};
        tbl[2] = '{len: 3, w: 4'd15, a: 4'h8, exp_sum: -46080};
        tbl[3] = '{len: 2, w: 4'd7,  a: 4'd7, exp_sum: 12544};

        fork
            // Array stub: fixed-latency result per start; forced values override the dot product.
            forever begin
                @(negedge clk);
                for (int i = STUB_DELAY - 1; i > 0; i--) begin
                    stub_v[i] = stub_v[i-1];
                    stub_d[i] = stub_d[i-1];
                end
                stub_v[0] = o_start;
                stub_d[0] = '0;
                if (o_start) stub_d[0] = (force_q.size() > 0) ? force_q.pop_front()
                                                                : dot16(o_weights_flat, o_acts_flat);
                i_done   = stub_v[STUB_DELAY-1];
                i_result = stub_d[STUB_DELAY-1];
            end
            forever begin
                @(negedge clk);
                if (o_start) begin
                    start_cnt++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                if (batch_done) begin
                    done_cnt++;
                    sum_at_done = batch_sum;
                end
                if (m_valid && m_ready) begin
                    pop_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL result_unexpected: got %0h, expected no output", {m_last, m_data});
                    end else begin
                        logic [16:0] e;
                        e = exp_q.pop_front();
                        if ({m_last, m_data} !== e) begin
                            errors++;
                            $display("FAIL result: got last=%0b data=%0h, expected last=%0b data=%0h",
                                     m_last, m_data, e[16], e[15:0]);
                        end
                    end
                end
            end
        join_none

        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_o_start", 32'(o_start), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_batch_done", 32'(batch_done), 32'd0);
        chk("rst_batch_sum", batch_sum, 32'd0);
        chk("rst_err_unexp", 32'(err_unexp), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Table of uniform batches.
        for (int k = 0; k < 4; k++) begin
            d0 = done_cnt; s0 = start_cnt; max_run = 0;
            send_cmd(tbl[k].len);
            w = {N{tbl[k].w}};
            a = {N{tbl[k].a}};
            for (int i = 0; i < tbl[k].len; i++)
                send_vec(w, a, {(i == tbl[k].len - 1), dot16(w, a)});
            wait_done(d0);
            wait_drain();
            chk("tbl_batch_sum", sum_at_done, 32'(tbl[k].exp_sum));
            chk("tbl_starts", 32'(start_cnt - s0), 32'(tbl[k].len));
            chk("tbl_done_once", 32'(done_cnt - d0), 32'd1);
            if (tbl[k].len == 4) chk("back_to_back_run", 32'(max_run), 32'd4);
        end

        // Zero-length batch: FINISH right after accept, no start, cmd_ready back next cycle.
        s0 = start_cnt;
        send_cmd(0);
        @(negedge clk);
        chk("len0_batch_done", 32'(batch_done), 32'd1);
        chk("len0_batch_sum", batch_sum, 32'd0);
        @(negedge clk);
        chk("len0_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("len0_done_low", 32'(batch_done), 32'd0);
        chk("len0_no_start", 32'(start_cnt - s0), 32'd0);

        // Backpressure: credit stops issue at FIFO_DEPTH outstanding results.
        m_ready = 1'b0;
        d0 = done_cnt; s0 = start_cnt; p0 = pop_cnt; model_sum = 0;
        send_cmd(40);
        for (int i = 0; i < 40; i++) begin
            w = '0; a = '0;
            for (int t = 0; t < N; t++) begin
                w[t*4 +: 4]   = 4'($urandom_range(0, 15));
                a[t*BW +: BW] = BW'($urandom_range(0, 15));
            end
            r = dot16(w, a);
            model_sum += int'($signed(r));
            if (i == FIFO_DEPTH) begin
                bad = 0;
                repeat (30) begin @(negedge clk); if (s_ready) bad++; end
                chk("credit_stall_s_ready", 32'(bad), 32'd0);
                chk("credit_fifo_full_valid", 32'(m_valid), 32'd1);
                chk("credit_starts", 32'(start_cnt - s0), 32'(FIFO_DEPTH));
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
            send_vec(w, a, {(i == 39), r});
        end
        wait_done(d0);
        wait_drain();
        chk("bp_pops", 32'(pop_cnt - p0), 32'd40);
        chk("bp_batch_sum", sum_at_done, 32'(model_sum));

        // Extreme results: sign must survive FIFO and accumulator.
        d0 = done_cnt;
        send_cmd(6);
        for (int i = 0; i < 6; i++) begin
            r = (i % 2 == 0) ? 16'h7fff : 16'h8000;
            force_q.push_back(r);
            send_vec('0, '0, {(i == 5), r});
        end
        wait_done(d0);
        wait_drain();
        chk("extreme_batch_sum", sum_at_done, 32'hffff_fffd);
        chk("extreme_no_err", 32'(err_unexp), 32'd0);

        // Reset during DRAIN with three results in flight.
        send_cmd(3);
        w = {N{4'd1}};
        a = {N{4'd1}};
        for (int i = 0; i < 3; i++) send_vec(w, a, {(i == 2), dot16(w, a)});
        @(posedge clk); #1;
        chk("pre_reset_drain", 32'(dbg_state), 32'd2);
        p0 = pop_cnt;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("async_rst_flats", 32'(|{o_weights_flat, o_acts_flat}), 32'd0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("async_rst_m_valid", 32'(m_valid), 32'd0);
        chk("async_rst_o_start", 32'(o_start), 32'd0);
        chk("async_rst_err", 32'(err_unexp), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("late_done_err_unexp", 32'(err_unexp), 32'd1);
        chk("late_done_dropped", 32'(pop_cnt - p0), 32'd0);
        chk("late_done_m_valid", 32'(m_valid), 32'd0);
        chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
